// File: rtl/debug_snapshot_responder.sv
// Debug snapshot responder for the VGA debug overlay.
// Captures GPR, CP0 and datapath debug words into the working half of a
// double buffer on each accepted frame_start, then swaps halves so the
// display always reads one coherent machine state.

module debug_snapshot_responder #(
    parameter int DP_WORDS = 26,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [6:0]               debug_addr,
    output logic [31:0]              debug_data,
    input  logic                     frame_start,
    input  logic                     freeze,
    input  logic [DP_WORDS*32-1:0]   dp_signals,
    output logic [4:0]               gpr_dbg_addr,
    input  logic [31:0]              gpr_dbg_data,
    output logic [4:0]               cp0_dbg_addr,
    input  logic [31:0]              cp0_dbg_data,
    output logic                     busy,
    output logic                     snap_valid,
    output logic [CNT_W-1:0]         snap_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        SWAP = 2'd2
    } state_t;

    // Upper bound on valid datapath word indices, in the width of the
    // comparison against the display address.
    localparam logic [5:0] DP_LIMIT = 6'(DP_WORDS);

    state_t            state;
    state_t            next_state;
    logic [5:0]        cnt;
    logic [5:0]        next_cnt;
    logic              disp_bank;
    logic              work_bank;
    logic              dp_we;
    logic              scan_we;
    logic              swap;
    logic [4:0]        dbg_addr;
    logic [4:0]        wr_idx;
    logic              dp_in_range;
    logic [31:0]       rd_word;

    // Storage for both banks; DP entries at or beyond DP_WORDS are never
    // written and are masked to zero on read.
    logic [31:0] gpr_mem [2][32];
    logic [31:0] cp0_mem [2][32];
    logic [31:0] dp_mem  [2][32];

    assign work_bank    = ~disp_bank;
    assign busy         = (state != IDLE);
    assign gpr_dbg_addr = dbg_addr;
    assign cp0_dbg_addr = dbg_addr;

    // Read data returned at count c belongs to the address issued at c-1;
    // at c=32 the 5-bit subtraction wraps to 31 as required.
    assign wr_idx      = cnt[4:0] - 5'd1;
    assign dp_in_range = ({1'b0, debug_addr[4:0]} < DP_LIMIT);

    // State register plus capture bookkeeping; reset aborts any capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 6'd0;
            disp_bank  <= 1'b0;
            snap_valid <= 1'b0;
            snap_count <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            if (swap) begin
                disp_bank  <= ~disp_bank;
                snap_valid <= 1'b1;
                snap_count <= snap_count + CNT_W'(1);
            end
        end
    end

    // Next-state logic and capture strobes for the IDLE/SCAN/SWAP sequence.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        dp_we      = 1'b0;
        scan_we    = 1'b0;
        swap       = 1'b0;
        dbg_addr   = 5'd0;
        case (state)
            IDLE: begin
                if (frame_start && !freeze) begin
                    next_state = SCAN;
                    next_cnt   = 6'd0;
                    dp_we      = 1'b1;
                end
            end
            SCAN: begin
                dbg_addr = cnt[5] ? 5'd0 : cnt[4:0];
                scan_we  = (cnt != 6'd0);
                next_cnt = cnt + 6'd1;
                if (cnt == 6'd32) begin
                    next_state = SWAP;
                end
            end
            SWAP: begin
                swap       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Bank writes into the working half; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (!rst && dp_we) begin
            for (int i = 0; i < DP_WORDS; i++) begin
                dp_mem[work_bank][i] <= dp_signals[i*32 +: 32];
            end
        end
        if (!rst && scan_we) begin
            gpr_mem[work_bank][wr_idx] <= gpr_dbg_data;
            cp0_mem[work_bank][wr_idx] <= cp0_dbg_data;
        end
    end

    // Display-side address decode from the displayed bank.
    always_comb begin
        rd_word = 32'd0;
        case (debug_addr[6:5])
            2'b00: rd_word = gpr_mem[disp_bank][debug_addr[4:0]];
            2'b01: begin
                if (dp_in_range) begin
                    rd_word = dp_mem[disp_bank][debug_addr[4:0]];
                end
            end
            2'b10: rd_word = cp0_mem[disp_bank][debug_addr[4:0]];
            default: rd_word = 32'd0;
        endcase
    end

    // Registered read port; zero until the first snapshot is swapped in.
    always_ff @(posedge clk) begin
        if (rst) begin
            debug_data <= 32'd0;
        end else begin
            debug_data <= snap_valid ? rd_word : 32'd0;
        end
    end

endmodule

// File: tb/tb_debug_snapshot_responder.sv
// Self-checking bench for debug_snapshot_responder. Display reads are
// scoreboarded: the expected word is queued when the address is driven and
// compared one edge later when the DUT registers debug_data.

module tb_debug_snapshot_responder;

    localparam int DP_WORDS = 26;
    localparam int CNT_W    = 16;

    logic                    clk;
    logic                    rst;
    logic [6:0]              debug_addr;
    logic [31:0]             debug_data;
    logic                    frame_start;
    logic                    freeze;
    logic [DP_WORDS*32-1:0]  dp_signals;
    logic [4:0]              gpr_dbg_addr;
    logic [31:0]             gpr_dbg_data;
    logic [4:0]              cp0_dbg_addr;
    logic [31:0]             cp0_dbg_data;
    logic                    busy;
    logic                    snap_valid;
    logic [CNT_W-1:0]        snap_count;

    logic [31:0]             gpr_base;
    logic [31:0]             cp0_base;

    int                      vectors;
    int                      miscompares;
    int                      cycles;

    logic [31:0]             exp_data_q[$];
    string                   exp_tag_q[$];

    debug_snapshot_responder #(
        .DP_WORDS(DP_WORDS),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .debug_addr(debug_addr),
        .debug_data(debug_data),
        .frame_start(frame_start),
        .freeze(freeze),
        .dp_signals(dp_signals),
        .gpr_dbg_addr(gpr_dbg_addr),
        .gpr_dbg_data(gpr_dbg_data),
        .cp0_dbg_addr(cp0_dbg_addr),
        .cp0_dbg_data(cp0_dbg_data),
        .busy(busy),
        .snap_valid(snap_valid),
        .snap_count(snap_count)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file and CP0 models: one-cycle registered debug read ports.
    always @(posedge clk) begin
        gpr_dbg_data <= gpr_base + {27'd0, gpr_dbg_addr};
        cp0_dbg_data <= cp0_base + {27'd0, cp0_dbg_addr};
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive a display address now and queue what must appear one edge later.
    task automatic issueRead(input logic [6:0] addr, input logic [31:0] expv, input string tag);
        debug_addr = addr;
        exp_data_q.push_back(expv);
        exp_tag_q.push_back(tag);
    endtask

    task automatic applyStimulus(input logic [6:0] addr, input logic [31:0] expv, input string tag);
        @(negedge clk);
        issueRead(addr, expv, tag);
    endtask

    task automatic drainReads();
        int n;
        n = 0;
        while (exp_data_q.size() > 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (exp_data_q.size() != 0) begin
            checkOutput("drain_timeout", 32'(exp_data_q.size()), 32'd0);
            exp_data_q.delete();
            exp_tag_q.delete();
        end
    endtask

    task automatic pulseFrame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // Scoreboard monitor: compare each queued read just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_data_q.size() > 0) begin
                checkOutput(exp_tag_q.pop_front(), debug_data, exp_data_q.pop_front());
            end
        end
    end

    // Watchdog so the run cannot hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        frame_start = 1'b0;
        freeze      = 1'b0;
        debug_addr  = 7'd0;
        gpr_base    = 32'hA000_0000;
        cp0_base    = 32'hC000_0000;
        for (int i = 0; i < DP_WORDS; i++) begin
            dp_signals[i*32 +: 32] = 32'h0D00_0000 + 32'(i);
        end
        dp_signals[3*32 +: 32] = 32'hDEAD_BEEF;

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state.
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_snap_valid", {31'd0, snap_valid}, 32'd0);
        checkOutput("rst_snap_count", {16'd0, snap_count}, 32'd0);
        checkOutput("rst_debug_data", debug_data, 32'd0);
        checkOutput("rst_gpr_dbg_addr", {27'd0, gpr_dbg_addr}, 32'd0);
        applyStimulus(7'h05, 32'd0, "rst_read_gpr");
        applyStimulus(7'h45, 32'd0, "rst_read_cp0");
        drainReads();

        // First snapshot; datapath word 3 changes after the accept edge.
        pulseFrame();
        cycles = 0;
        while (busy && cycles < 200) begin
            if (cycles == 1) begin
                dp_signals[3*32 +: 32] = 32'h1234_5678;
            end
            if (cycles == 7) begin
                checkOutput("scan_gpr_addr", {27'd0, gpr_dbg_addr}, 32'd7);
                checkOutput("scan_cp0_addr", {27'd0, cp0_dbg_addr}, 32'd7);
            end
            cycles++;
            @(negedge clk);
        end
        checkOutput("busy_cycles_1", 32'(cycles), 32'd34);
        checkOutput("snap_count_1", {16'd0, snap_count}, 32'd1);
        checkOutput("snap_valid_1", {31'd0, snap_valid}, 32'd1);
        checkOutput("idle_dbg_addr", {27'd0, gpr_dbg_addr}, 32'd0);
        applyStimulus(7'h05, 32'hA000_0005, "gpr_5");
        applyStimulus(7'h45, 32'hC000_0005, "cp0_5");
        applyStimulus(7'h60, 32'd0, "group3");
        applyStimulus(7'h23, 32'hDEAD_BEEF, "dp_3_coherent");
        applyStimulus(7'h3A, 32'd0, "dp_beyond");
        applyStimulus(7'h39, 32'h0D00_0019, "dp_last");
        applyStimulus(7'h20, 32'h0D00_0000, "dp_0");
        applyStimulus(7'h00, 32'hA000_0000, "gpr_0");
        applyStimulus(7'h1F, 32'hA000_001F, "gpr_31");
        applyStimulus(7'h5F, 32'hC000_001F, "cp0_31");
        drainReads();

        // Coherence across a second capture, with a frame_start during SCAN.
        gpr_base = 32'hB000_0000;
        pulseFrame();
        cycles = 0;
        while (busy && cycles < 200) begin
            issueRead(7'h1F, 32'hA000_001F, "coherent_scan");
            frame_start = (cycles == 10) || (cycles == 33);
            cycles++;
            @(negedge clk);
        end
        frame_start = 1'b0;
        issueRead(7'h1F, 32'hB000_001F, "coherent_new");
        checkOutput("busy_cycles_2", 32'(cycles), 32'd34);
        checkOutput("snap_count_2", {16'd0, snap_count}, 32'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("no_queue", {31'd0, busy}, 32'd0);
        end
        drainReads();

        // frame_start while frozen is ignored.
        freeze = 1'b1;
        pulseFrame();
        for (int i = 0; i < 3; i++) begin
            checkOutput("frozen_busy", {31'd0, busy}, 32'd0);
            @(negedge clk);
        end
        checkOutput("frozen_count", {16'd0, snap_count}, 32'd2);

        // freeze rising mid-capture does not stop it.
        freeze   = 1'b0;
        cp0_base = 32'hC100_0000;
        pulseFrame();
        cycles = 0;
        while (busy && cycles < 200) begin
            if (cycles == 5) begin
                freeze = 1'b1;
            end
            cycles++;
            @(negedge clk);
        end
        freeze = 1'b0;
        checkOutput("busy_cycles_3", 32'(cycles), 32'd34);
        checkOutput("snap_count_3", {16'd0, snap_count}, 32'd3);
        applyStimulus(7'h45, 32'hC100_0005, "cp0_after_freeze");
        applyStimulus(7'h23, 32'h1234_5678, "dp_3_new");
        drainReads();

        // Reset at SCAN count 15 aborts the capture.
        gpr_base = 32'hE000_0000;
        pulseFrame();
        cycles = 0;
        while (busy && cycles < 15) begin
            cycles++;
            @(negedge clk);
        end
        checkOutput("abort_point", {27'd0, gpr_dbg_addr}, 32'd15);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_snap_valid", {31'd0, snap_valid}, 32'd0);
        checkOutput("abort_snap_count", {16'd0, snap_count}, 32'd0);
        checkOutput("abort_debug_data", debug_data, 32'd0);
        applyStimulus(7'h05, 32'd0, "abort_read");
        drainReads();

        // Full capture after the abort.
        pulseFrame();
        cycles = 0;
        while (busy && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
        checkOutput("busy_cycles_4", 32'(cycles), 32'd34);
        checkOutput("snap_count_4", {16'd0, snap_count}, 32'd1);
        applyStimulus(7'h05, 32'hE000_0005, "gpr_after_abort");
        applyStimulus(7'h45, 32'hC100_0005, "cp0_after_abort");
        applyStimulus(7'h23, 32'h1234_5678, "dp_after_abort");
        drainReads();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
